fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter ADDR_W SHALL default 32: width of every address and PC signal.
REQ-002 Parameter RESET_PC SHALL default 32'h0000_3000: PC loaded on reset.
REQ-003 Parameter EXC_PC SHALL default 32'h0000_4180: exception handler entry.
REQ-004 Parameters TEXT_LO/TEXT_HI SHALL default 32'h0000_3000/32'h0000_6FFC: inclusive legal fetch range.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 F_en  in  1  pipeline advance permission from hazard unit.
REQ-008 NPC  in  ADDR_W  next sequential/branch PC.
REQ-009 req_exc  in  1  exception redirect request.
REQ-010 eret  in  1  return-from-exception request.
REQ-011 EPC  in  ADDR_W  eret target.
REQ-012 imem_req  out  1  instruction-memory request valid.
REQ-013 imem_addr  out  ADDR_W  request address.
REQ-014 imem_ready  in  1  memory accepts request; imem_rdata valid same cycle.
REQ-015 imem_rdata  in  32  instruction word.
REQ-016 F_PC  out  ADDR_W  current fetch PC.
REQ-017 F_instr  out  32  fetched instruction (0 = nop on fault).
REQ-018 F_valid  out  1  F_instr/F_AdEL valid for F_PC.
REQ-019 F_AdEL  out  1  fetch address fault (misaligned or outside TEXT_LO..TEXT_HI).
REQ-020 F_busy  out  1  high whenever F_valid is low; stall request to hazard unit.

Function
REQ-021 States SHALL be REQ (fetch pending), DRAIN (discarding aborted access), DONE (instruction held).
REQ-022 In REQ with legal F_PC: imem_req=1, imem_addr=F_PC, held stable until imem_ready; on imem_ready capture imem_rdata into F_instr, F_AdEL=0, go DONE (1-cycle min latency).
REQ-023 In REQ with illegal F_PC (F_PC[1:0]!=0, <TEXT_LO or >TEXT_HI): imem_req=0, next cycle F_instr=0, F_AdEL=1, DONE.
REQ-024 In DONE: F_valid=1; F_en=1 loads F_PC<=NPC, goes REQ, F_valid=0 next cycle; F_en=0 holds everything.
REQ-025 F_en SHALL be ignored in REQ and DRAIN (PC holds).
REQ-026 Redirect priority SHALL be req_exc > eret > F_en; req_exc loads EXC_PC, eret loads EPC, in any state, regardless of F_en.
REQ-027 Redirect in REQ with imem_req=1 and imem_ready=0 SHALL go DRAIN, keep imem_req=1 at old address until imem_ready, discard data, then REQ at new PC.
REQ-028 Redirect in REQ with imem_ready=1 same cycle, or in DONE, SHALL discard data and go REQ directly.
REQ-029 Redirect during DRAIN SHALL overwrite the pending target (latest wins by priority), stay in DRAIN until imem_ready.
REQ-030 F_PC SHALL never be updated arithmetically inside the block; no wrap logic (NPC supplied externally).

Reset
REQ-031 Reset SHALL force F_PC=RESET_PC, state=REQ, F_instr=0, F_valid=0, F_AdEL=0, pending target cleared.
REQ-032 Reset mid-access SHALL abandon it with no DRAIN; imem_req may assert at RESET_PC on first cycle after release.

Structure
REQ-033 Package fetch_pkg SHALL hold default RESET_PC, EXC_PC, TEXT_LO, TEXT_HI and the state enum.
REQ-034 Sub-module fetch_addr_chk (combinational alignment/range check, outputs fault bit) SHALL be instantiated once.

Verification
REQ-035 Reset release, imem_ready tied 1 -> imem_addr=0x3000 cycle 1, F_valid=1 cycle 2 with F_instr=imem_rdata.
REQ-036 DONE, F_en=1, NPC=0x3004, imem_ready low 3 cycles -> imem_addr 0x3004 stable 4 cycles, F_busy high, then F_valid.
REQ-037 NPC=0x3002 -> no imem_req, F_AdEL=1, F_instr=0 next cycle; NPC=0x7000 -> same.
REQ-038 req_exc during REQ with imem_ready=0 at 0x3008 -> DRAIN holds 0x3008 until ready, data dropped, then fetch 0x4180.
REQ-039 req_exc and eret (EPC=0x3010) same cycle -> F_PC=0x4180; eret alone -> F_PC=0x3010.
REQ-040 Async reset pulse mid-DRAIN -> outputs reset values immediately, no clock edge needed.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: default fetch addresses and the fetch FSM state encoding
package fetch_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO_DEF  = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI_DEF  = 32'h0000_6FFC;
    typedef logic [1:0] state_t;
    localparam state_t S_REQ   = 2'd0;
    localparam state_t S_DRAIN = 2'd1;
    localparam state_t S_DONE  = 2'd2;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request bus
//   master (fetch side): drives imem_req/imem_addr, receives imem_ready/imem_rdata
//   slave  (memory side): the reverse
interface fetch_if #(parameter int ADDR_W = 32);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;
    modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_addr_chk.sv
// fetch_addr_chk: flags a fetch address that is misaligned or outside [TEXT_LO, TEXT_HI]
//   addr  in  fetch address
//   fault out 1 when the address must not be fetched
module fetch_addr_chk
    import fetch_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] TEXT_LO = ADDR_W'(TEXT_LO_DEF),
    parameter logic [ADDR_W-1:0] TEXT_HI = ADDR_W'(TEXT_HI_DEF)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              fault
);
    assign fault = (|addr[1:0]) || (addr < TEXT_LO) || (addr > TEXT_HI);
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller with redirect and aborted-access drain
//   clk, reset        clock, async active-high reset
//   F_en, NPC         advance permission and next PC from the pipeline
//   req_exc           redirect to EXC_PC (highest priority)
//   eret, EPC         redirect to EPC
//   imem              instruction-memory bus (master side)
//   F_PC, F_instr     current fetch PC and its instruction (0 on fault)
//   F_valid, F_AdEL   instruction held / fetch address fault
//   F_busy            stall request, inverse of F_valid
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_PC_DEF),
    parameter logic [ADDR_W-1:0] TEXT_LO  = ADDR_W'(TEXT_LO_DEF),
    parameter logic [ADDR_W-1:0] TEXT_HI  = ADDR_W'(TEXT_HI_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              F_en,
    input  logic [ADDR_W-1:0] NPC,
    input  logic              req_exc,
    input  logic              eret,
    input  logic [ADDR_W-1:0] EPC,
    fetch_if.master           imem,
    output logic [ADDR_W-1:0] F_PC,
    output logic [31:0]       F_instr,
    output logic              F_valid,
    output logic              F_AdEL,
    output logic              F_busy
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pend_q, pend_d;
    logic [31:0]       instr_q, instr_d;
    logic              adel_q, adel_d;
    logic              fault, redir;
    logic [ADDR_W-1:0] tgt;

    fetch_addr_chk #(.ADDR_W(ADDR_W), .TEXT_LO(TEXT_LO), .TEXT_HI(TEXT_HI)) u_chk (
        .addr  (pc_q),
        .fault (fault)
    );

    assign redir          = req_exc | eret;
    assign tgt            = req_exc ? EXC_PC : EPC;
    // F_PC keeps the aborted address during DRAIN so the memory sees a stable request
    assign imem.imem_req  = (state_q == S_DRAIN) || (state_q == S_REQ && !fault);
    assign imem.imem_addr = pc_q;
    assign F_PC           = pc_q;
    assign F_instr        = instr_q;
    assign F_AdEL         = adel_q;
    assign F_valid        = state_q == S_DONE;
    assign F_busy         = !F_valid;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        instr_d = instr_q;
        adel_d  = adel_q;
        if (state_q == S_REQ) begin
            if (redir && imem.imem_req && !imem.imem_ready) begin
                state_d = S_DRAIN;
                pend_d  = tgt;
            end else if (redir) begin
                pc_d = tgt;
            end else if (fault) begin
                state_d = S_DONE;
                instr_d = 32'd0;
                adel_d  = 1'b1;
            end else if (imem.imem_ready) begin
                state_d = S_DONE;
                instr_d = imem.imem_rdata;
                adel_d  = 1'b0;
            end
        end else if (state_q == S_DRAIN) begin
            // a redirect arriving with the final ready still wins
            pend_d = redir ? tgt : pend_q;
            if (imem.imem_ready) begin
                state_d = S_REQ;
                pc_d    = pend_d;
            end
        end else if (redir || F_en) begin
            state_d = S_REQ;
            pc_d    = redir ? tgt : NPC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            instr_q <= 32'd0;
            adel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            instr_q <= instr_d;
            adel_q  <= adel_d;
        end
    end
endmodule
